// File: rtl/spi_xfer_sched.sv
// Transfer scheduler: pops TX FIFO words into the SPI shift engine and pushes received words to the RX FIFO.
// Define SPI_SCHED_TIMEOUT_EN to add the engine watchdog and the sticky error_o flag.
module spi_xfer_sched #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  soft_rst_i,
    input  logic                  enable_i,
    input  logic [REG_WIDTH-1:0]  burst_len_i,
    input  logic                  tx_empty_i,
    output logic                  tx_req_o,
    input  logic                  tx_resp_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ack_o,
    output logic                  eng_start_o,
    output logic [DATA_WIDTH-1:0] eng_data_o,
    input  logic                  eng_done_i,
    input  logic [DATA_WIDTH-1:0] eng_data_i,
    input  logic                  rx_full_i,
    output logic                  rx_req_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ack_i,
    output logic                  busy_o,
    output logic                  burst_done_o,
    output logic [REG_WIDTH-1:0]  xfer_cnt_o,
    output logic                  error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_SHIFT,
        S_STORE,
        S_NEXT
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [REG_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] eng_data_q, rx_data_q;
    logic                  tx_ack_q, tx_ack_d;
    logic                  burst_done_q, burst_done_d;
    logic                  load_tx, load_rx;
    logic                  timeout;
    logic                  error_q;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q;

    // Counts cycles spent in SHIFT; timeout fires in the last allowed cycle if the engine is still busy.
    assign timeout = (state_q == S_SHIFT) && !eng_done_i &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else if (soft_rst_i) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            timer_q <= (state_q == S_SHIFT) ? timer_q + TW'(1) : '0;
            if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign error_q = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_ack_d     = 1'b0;
        burst_done_d = 1'b0;
        load_tx      = 1'b0;
        load_rx      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i && !tx_empty_i && !error_q) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (tx_resp_i) begin
                    load_tx  = 1'b1;
                    tx_ack_d = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: state_d = S_SHIFT;
            S_SHIFT: begin
                if (eng_done_i) begin
                    load_rx = 1'b1;
                    state_d = S_STORE;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_STORE: begin
                if (rx_ack_i) begin
                    cnt_d   = cnt_q + REG_WIDTH'(1);
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // A zero burst length means continuous mode: the count just wraps.
                if ((burst_len_i != '0) && (cnt_q == burst_len_i)) begin
                    burst_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else if (enable_i && !tx_empty_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            // NOTE: the data holding registers are reset too, because their values are visible on ports.
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            eng_data_q   <= '0;
            rx_data_q    <= '0;
            tx_ack_q     <= 1'b0;
            burst_done_q <= 1'b0;
        end else if (soft_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            eng_data_q   <= '0;
            rx_data_q    <= '0;
            tx_ack_q     <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_ack_q     <= tx_ack_d;
            burst_done_q <= burst_done_d;
            if (load_tx) begin
                eng_data_q <= tx_data_i;
            end
            if (load_rx) begin
                rx_data_q <= eng_data_i;
            end
        end
    end

    assign tx_req_o     = (state_q == S_FETCH);
    assign tx_ack_o     = tx_ack_q;
    assign eng_start_o  = (state_q == S_START);
    assign eng_data_o   = eng_data_q;
    assign rx_req_o     = (state_q == S_STORE) && !rx_full_i;
    assign rx_data_o    = rx_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign burst_done_o = burst_done_q;
    assign xfer_cnt_o   = cnt_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched: FIFO/engine responders plus a queue-based model of the
// expected RX stream, transfer count and burst completions.
`timescale 1ns/1ps
module tb_spi_xfer_sched;

    localparam int DW     = 16;
    localparam int RW     = 4;     // narrow count register so wrap-around is reachable quickly
    localparam int TO     = 16;
    localparam int BUDGET = 2000;

    logic          clk_i = 1'b0;
    logic          arst_n_i;
    logic          soft_rst_i;
    logic          enable_i;
    logic [RW-1:0] burst_len_i;
    logic          tx_empty_i = 1'b1;
    logic          tx_req_o;
    logic          tx_resp_i = 1'b0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_ack_o;
    logic          eng_start_o;
    logic [DW-1:0] eng_data_o;
    logic          eng_done_i = 1'b0;
    logic [DW-1:0] eng_data_i = '0;
    logic          rx_full_i;
    logic          rx_req_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_ack_i = 1'b0;
    logic          busy_o;
    logic          burst_done_o;
    logic [RW-1:0] xfer_cnt_o;
    logic          error_o;

    spi_xfer_sched #(
        .DATA_WIDTH    (DW),
        .REG_WIDTH     (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .soft_rst_i  (soft_rst_i),
        .enable_i    (enable_i),
        .burst_len_i (burst_len_i),
        .tx_empty_i  (tx_empty_i),
        .tx_req_o    (tx_req_o),
        .tx_resp_i   (tx_resp_i),
        .tx_data_i   (tx_data_i),
        .tx_ack_o    (tx_ack_o),
        .eng_start_o (eng_start_o),
        .eng_data_o  (eng_data_o),
        .eng_done_i  (eng_done_i),
        .eng_data_i  (eng_data_i),
        .rx_full_i   (rx_full_i),
        .rx_req_o    (rx_req_o),
        .rx_data_o   (rx_data_o),
        .rx_ack_i    (rx_ack_i),
        .busy_o      (busy_o),
        .burst_done_o(burst_done_o),
        .xfer_cnt_o  (xfer_cnt_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    // TX FIFO contents (written by the stimulus, read by the responder) and observed/expected streams.
    logic [DW-1:0] tx_mem [0:511];
    int            tx_wr = 0;
    int            tx_rd = 0;
    int            tx_wait = 0;
    logic [DW-1:0] rx_log [$];
    logic [DW-1:0] exp_rx [$];
    int            ack_cnt = 0;
    int            bd_cnt = 0;
    int            start_cnt = 0;
    int            done_cnt = 0;
    int            proto_err = 0;
    bit            eng_busy = 1'b0;
    int            eng_delay = 0;
    logic [DW-1:0] eng_word = '0;
    bit            hold_all = 1'b0;
    int            hold_at = -1;
    int            checks = 0;
    int            errors = 0;
    int            exp_cnt = 0;

    // FIFO and loopback-engine responders, all acting on the falling edge.
    always @(negedge clk_i) begin
        if (tx_ack_o) begin
            ack_cnt++;
            if (tx_rd == tx_wr) proto_err++;
            else tx_rd++;
        end
        if (!tx_req_o) begin
            tx_resp_i = 1'b0;
            tx_wait   = $urandom_range(0, 2);
        end else if (!tx_resp_i) begin
            if (tx_rd == tx_wr) begin
                proto_err++;
            end else if (tx_wait == 0) begin
                tx_resp_i = 1'b1;
                tx_data_i = tx_mem[tx_rd];
            end else begin
                tx_wait--;
            end
        end
        tx_empty_i = (tx_rd == tx_wr);

        if (!arst_n_i || soft_rst_i) begin
            eng_busy   = 1'b0;
            eng_done_i = 1'b0;
        end else begin
            eng_done_i = 1'b0;
            if (eng_start_o) begin
                if (eng_busy) proto_err++;
                start_cnt++;
                eng_busy  = 1'b1;
                eng_word  = eng_data_o;
                eng_delay = $urandom_range(0, 4);
            end else if (eng_busy) begin
                if (eng_data_o !== eng_word) proto_err++;
                if (!hold_all && start_cnt != hold_at) begin
                    if (eng_delay == 0) begin
                        eng_done_i = 1'b1;
                        eng_data_i = eng_word;
                        eng_busy   = 1'b0;
                        done_cnt++;
                    end else begin
                        eng_delay--;
                    end
                end
            end
        end

        rx_ack_i = 1'b0;
        if (rx_req_o) begin
            if (rx_full_i) proto_err++;
            else begin
                rx_ack_i = 1'b1;
                rx_log.push_back(rx_data_o);
            end
        end
        if (burst_done_o) bd_cnt++;
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit expect_it);
        tx_mem[tx_wr] = w;
        tx_wr++;
        if (expect_it) exp_rx.push_back(w);
    endtask

    task automatic soft_reset();
        soft_rst_i = 1'b1;
        tick();
        soft_rst_i = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick();
        while (!(busy_o === 1'b0 && (tx_rd == tx_wr || enable_i == 1'b0)) && n < BUDGET) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, BUDGET);
        end
    endtask

    task automatic wait_start(input int target, input string name);
        int n = 0;
        while (start_cnt < target && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (start_cnt < target) begin
            errors++;
            $display("FAIL %s_start: %0d engine starts, required %0d", name, start_cnt, target);
        end
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (rx_log.size() != exp_rx.size()) begin
            errors++;
            $display("FAIL %s_rx_count: got %0d words, required %0d", name, rx_log.size(), exp_rx.size());
        end
        for (int i = 0; i < exp_rx.size() && i < rx_log.size(); i++) begin
            checks++;
            if (rx_log[i] !== exp_rx[i]) begin
                errors++;
                $display("FAIL %s_rx_word%0d: got %h required %h", name, i, rx_log[i], exp_rx[i]);
            end
        end
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o, error_o} !== 7'b0 ||
            eng_data_o !== '0 || rx_data_o !== '0 || xfer_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b eng=%h rx=%h cnt=%h, required all 0",
                     {tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o, error_o},
                     eng_data_o, rx_data_o, xfer_cnt_o);
        end
        arst_n_i = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid_shift();
        int a0;
        hold_all = 1'b1;
        burst_len_i = '0;
        push_word(16'h3C3C, 1'b0);
        enable_i = 1'b1;
        wait_start(start_cnt + 1, "rst_mid");
        tick();
        checks++;
        if (busy_o !== 1'b1 || eng_data_o !== 16'h3C3C) begin
            errors++;
            $display("FAIL rst_mid_shift_state: busy=%b eng=%h, required 1 3c3c", busy_o, eng_data_o);
        end
        enable_i = 1'b0;
        arst_n_i = 1'b0;
        #1;
        checks++;
        if ({tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o} !== 6'b0 ||
            eng_data_o !== '0 || rx_data_o !== '0 || xfer_cnt_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ctl=%b eng=%h rx=%h cnt=%h, required all 0",
                     {tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o},
                     eng_data_o, rx_data_o, xfer_cnt_o);
        end
        tick();
        a0 = ack_cnt;
        arst_n_i = 1'b1;
        hold_all = 1'b0;
        repeat (8) tick();
        checks++;
        if (ack_cnt != a0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: acks=%0d busy=%b, required %0d 0", ack_cnt, busy_o, a0);
        end
        exp_cnt = 0;
    endtask

    task automatic test_burst3();
        int a0, b0;
        burst_len_i = RW'(3);
        push_word(16'hA5A5, 1'b1);
        push_word(16'h1234, 1'b1);
        push_word(16'hFFFF, 1'b1);
        a0 = ack_cnt;
        b0 = bd_cnt;
        enable_i = 1'b1;
        wait_idle("burst3");
        enable_i = 1'b0;
        checks++;
        if (ack_cnt - a0 != 3) begin
            errors++;
            $display("FAIL burst3_acks: got %0d pulses, required 3", ack_cnt - a0);
        end
        checks++;
        if (bd_cnt - b0 != 1) begin
            errors++;
            $display("FAIL burst3_done: got %0d pulses, required 1", bd_cnt - b0);
        end
        checks++;
        if (xfer_cnt_o !== '0) begin
            errors++;
            $display("FAIL burst3_cnt: got %0d, required 0", xfer_cnt_o);
        end
        compare_stream("burst3");
    endtask

    task automatic test_rx_full();
        int b0, r0, n;
        rx_full_i = 1'b1;
        burst_len_i = RW'(1);
        push_word(16'h00C3, 1'b1);
        b0 = bd_cnt;
        r0 = rx_log.size();
        enable_i = 1'b1;
        n = 0;
        while (done_cnt == 0 || eng_busy || start_cnt == 0 || busy_o !== 1'b1 || dut_in_shift()) begin
            if (n >= BUDGET) break;
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rx_req_o !== 1'b0 || busy_o !== 1'b1 || rx_log.size() != r0) begin
                errors++;
                $display("FAIL rxfull_stall_c%0d: rx_req=%b busy=%b writes=%0d, required 0 1 %0d",
                         i, rx_req_o, busy_o, rx_log.size(), r0);
            end
        end
        rx_full_i = 1'b0;
        wait_idle("rxfull");
        enable_i = 1'b0;
        checks++;
        if (rx_log.size() != r0 + 1 || bd_cnt - b0 != 1) begin
            errors++;
            $display("FAIL rxfull_release: writes=%0d done=%0d, required 1 1", rx_log.size() - r0, bd_cnt - b0);
        end
        compare_stream("rxfull");
    endtask

    // True while the bench engine still owes a done pulse for the latest start.
    function automatic bit dut_in_shift();
        return eng_busy || (start_cnt != done_cnt);
    endfunction

    task automatic test_tx_underflow();
        int b0;
        burst_len_i = RW'(4);
        b0 = bd_cnt;
        push_word(DW'($urandom), 1'b1);
        push_word(DW'($urandom), 1'b1);
        enable_i = 1'b1;
        wait_idle("underflow_a");
        checks++;
        if (xfer_cnt_o !== RW'(2) || busy_o !== 1'b0 || bd_cnt != b0) begin
            errors++;
            $display("FAIL underflow_paused: cnt=%0d busy=%b done=%0d, required 2 0 0",
                     xfer_cnt_o, busy_o, bd_cnt - b0);
        end
        push_word(DW'($urandom), 1'b1);
        push_word(DW'($urandom), 1'b1);
        wait_idle("underflow_b");
        enable_i = 1'b0;
        checks++;
        if (bd_cnt - b0 != 1 || xfer_cnt_o !== '0) begin
            errors++;
            $display("FAIL underflow_resume: done=%0d cnt=%0d, required 1 0", bd_cnt - b0, xfer_cnt_o);
        end
        compare_stream("underflow");
    endtask

    task automatic test_continuous();
        burst_len_i = '0;
        hold_at = start_cnt + 5;
        for (int i = 0; i < 7; i++) push_word(DW'($urandom), 1'b1);
        enable_i = 1'b1;
        wait_start(hold_at, "cont");
        tick();
        enable_i = 1'b0;
        hold_at = -1;
        wait_idle("cont_stop");
        exp_cnt = 5;
        checks++;
        if (xfer_cnt_o !== RW'(exp_cnt) || busy_o !== 1'b0 || tx_wr - tx_rd != 2) begin
            errors++;
            $display("FAIL cont_stop: cnt=%0d busy=%b left=%0d, required %0d 0 2",
                     xfer_cnt_o, busy_o, tx_wr - tx_rd, exp_cnt);
        end
        enable_i = 1'b1;
        wait_idle("cont_resume");
        enable_i = 1'b0;
        exp_cnt = 7;
        checks++;
        if (xfer_cnt_o !== RW'(exp_cnt)) begin
            errors++;
            $display("FAIL cont_resume_cnt: got %0d, required %0d", xfer_cnt_o, exp_cnt);
        end
        compare_stream("cont");
    endtask

    task automatic test_soft_reset();
        int a0;
        hold_all = 1'b1;
        push_word(16'h5AA5, 1'b0);
        enable_i = 1'b1;
        wait_start(start_cnt + 1, "softrst");
        repeat (2) tick();
        soft_reset();
        checks++;
        if ({tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o} !== 6'b0 ||
            eng_data_o !== '0 || rx_data_o !== '0 || xfer_cnt_o !== '0) begin
            errors++;
            $display("FAIL softrst_outputs: ctl=%b eng=%h rx=%h cnt=%h, required all 0",
                     {tx_req_o, tx_ack_o, eng_start_o, rx_req_o, busy_o, burst_done_o},
                     eng_data_o, rx_data_o, xfer_cnt_o);
        end
        enable_i = 1'b0;
        hold_all = 1'b0;
        a0 = ack_cnt;
        repeat (5) tick();
        checks++;
        if (ack_cnt != a0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL softrst_after: acks=%0d busy=%b, required %0d 0", ack_cnt, busy_o, a0);
        end
    endtask

    task automatic test_wrap();
        burst_len_i = '0;
        for (int i = 0; i < 20; i++) push_word(DW'($urandom), 1'b1);
        enable_i = 1'b1;
        wait_idle("wrap");
        enable_i = 1'b0;
        exp_cnt = (exp_cnt + 20) % (1 << RW);
        checks++;
        if (xfer_cnt_o !== RW'(exp_cnt)) begin
            errors++;
            $display("FAIL wrap_cnt: got %0d, required %0d", xfer_cnt_o, exp_cnt);
        end
        compare_stream("wrap");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            bit cont;
            int n, b0, exp_bd;
            cont = ($urandom_range(0, 3) == 0);
            n = cont ? $urandom_range(1, 6) : $urandom_range(1, 5);
            if (!cont && exp_cnt != 0) soft_reset();
            burst_len_i = cont ? '0 : RW'(n);
            b0 = bd_cnt;
            for (int i = 0; i < n; i++) push_word(DW'($urandom), 1'b1);
            enable_i = 1'b1;
            wait_idle("random");
            enable_i = 1'b0;
            if (cont) begin
                exp_cnt = (exp_cnt + n) % (1 << RW);
                exp_bd  = 0;
            end else begin
                exp_cnt = 0;
                exp_bd  = 1;
            end
            checks++;
            if (xfer_cnt_o !== RW'(exp_cnt) || bd_cnt - b0 != exp_bd) begin
                errors++;
                $display("FAIL random_r%0d: cnt=%0d done=%0d, required %0d %0d",
                         r, xfer_cnt_o, bd_cnt - b0, exp_cnt, exp_bd);
            end
        end
        compare_stream("random");
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int a0, r0;
        soft_reset();
        hold_all = 1'b1;
        burst_len_i = '0;
        push_word(16'hDEAD, 1'b0);
        r0 = rx_log.size();
        enable_i = 1'b1;
        wait_start(start_cnt + 1, "timeout");
        repeat (TO) tick();
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: error=%b busy=%b, required 0 1", error_o, busy_o);
        end
        tick();
        checks++;
        if (error_o !== 1'b1 || busy_o !== 1'b0 || xfer_cnt_o !== '0 || rx_log.size() != r0) begin
            errors++;
            $display("FAIL timeout_fire: error=%b busy=%b cnt=%0d writes=%0d, required 1 0 0 0",
                     error_o, busy_o, xfer_cnt_o, rx_log.size() - r0);
        end
        push_word(16'h0F0F, 1'b1);
        a0 = ack_cnt;
        repeat (10) tick();
        checks++;
        if (busy_o !== 1'b0 || ack_cnt != a0 || error_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_locked: busy=%b acks=%0d error=%b, required 0 %0d 1",
                     busy_o, ack_cnt, error_o, a0);
        end
        soft_reset();
        hold_all = 1'b0;
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: error=%b required 0", error_o);
        end
        wait_idle("timeout_resume");
        enable_i = 1'b0;
        compare_stream("timeout");
    endtask
`else
    task automatic test_error_tied();
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL error_tied: got %b required 0", error_o);
        end
    endtask
`endif

    task automatic test_protocol();
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL protocol: %0d handshake violations, required 0", proto_err);
        end
    endtask

    initial begin
        arst_n_i    = 1'b0;
        soft_rst_i  = 1'b0;
        enable_i    = 1'b0;
        burst_len_i = '0;
        rx_full_i   = 1'b0;
        test_reset();
        test_reset_mid_shift();
        test_burst3();
        test_rx_full();
        test_tx_underflow();
        test_continuous();
        test_soft_reset();
        test_wrap();
        test_random();
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_error_tied();
`endif
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
